double_comparator: RTL

//  Responder-side IEEE-754 binary64 compare core. Uses the same two-operand stb/ack handshake the FPU wrapper drives

---
 rtl/double_comparator.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/double_comparator.sv
// double_comparator: IEEE-754 binary64 compare core behind a two-operand stb/ack handshake.
// The core takes operand A, then operand B. It classifies the pair and returns
// {59'b0, inv, unord, gt, eq, lt} on o_z. The result is held until the initiator acks it.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_a, i_a_stb, o_a_ack operand A channel (transfer on i_a_stb & o_a_ack)
//   i_b, i_b_stb, o_b_ack operand B channel (transfer on i_b_stb & o_b_ack)
//   o_z, o_z_stb, i_z_ack result channel (transfer on o_z_stb & i_z_ack)
//
// Build option:
//   FPU_CMP_INVALID_EN  when defined, o_z[4] (inv) flags a signalling NaN operand;
//                       when undefined, o_z[4] is 0 and sNaN behaves as qNaN.
//
// W_DATA must be left at 64; the core handles binary64 only.

module double_comparator #(
    parameter int unsigned W_DATA = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [W_DATA-1:0] i_a,
    input  logic              i_a_stb,
    output logic              o_a_ack,
    input  logic [W_DATA-1:0] i_b,
    input  logic              i_b_stb,
    output logic              o_b_ack,
    output logic [W_DATA-1:0] o_z,
    output logic              o_z_stb,
    input  logic              i_z_ack
);

    localparam int unsigned W_EXP  = 11;
    localparam int unsigned W_FRAC = 52;
    localparam int unsigned W_MAG  = W_EXP + W_FRAC;
    localparam int unsigned W_RES  = 5;

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        UNPACK  = 3'd2,
        COMPARE = 3'd3,
        PUT_Z   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                a_ack_q, a_ack_d;
    logic                b_ack_q, b_ack_d;
    logic                z_stb_q, z_stb_d;
    logic [W_DATA-1:0]   z_q, z_d;
    logic [W_DATA-1:0]   a_q, a_d;
    logic [W_DATA-1:0]   b_q, b_d;

    // Unpacked operand fields and classification flags
    logic                sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [W_MAG-1:0]    mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic                nan_a_q, nan_a_d, nan_b_q, nan_b_d;
    logic                zero_a_q, zero_a_d, zero_b_q, zero_b_d;
`ifdef FPU_CMP_INVALID_EN
    logic                snan_a_q, snan_a_d, snan_b_q, snan_b_d;
`endif

    // Compare result {inv, unord, gt, eq, lt}
    logic [W_RES-1:0]    res_q, res_d;

    logic                lt_c, eq_c, gt_c, unord_c, inv_c;

    // Classification of the latched operands (used in UNPACK)
    logic [W_EXP-1:0]    exp_a_c, exp_b_c;
    logic [W_FRAC-1:0]   frac_a_c, frac_b_c;

    assign exp_a_c  = a_q[W_DATA-2 -: W_EXP];
    assign exp_b_c  = b_q[W_DATA-2 -: W_EXP];
    assign frac_a_c = a_q[W_FRAC-1:0];
    assign frac_b_c = b_q[W_FRAC-1:0];

    // Ordered compare of the unpacked pair; first matching rule wins
    always_comb begin
        lt_c    = 1'b0;
        eq_c    = 1'b0;
        gt_c    = 1'b0;
        unord_c = 1'b0;
        if (nan_a_q || nan_b_q) begin
            unord_c = 1'b1;
        end else if (zero_a_q && zero_b_q) begin
            eq_c = 1'b1;
        end else if ({sign_a_q, mag_a_q} == {sign_b_q, mag_b_q}) begin
            eq_c = 1'b1;
        end else if (sign_a_q != sign_b_q) begin
            lt_c = sign_a_q;
            gt_c = sign_b_q;
        end else if (!sign_a_q) begin
            lt_c = (mag_a_q < mag_b_q);
            gt_c = (mag_a_q > mag_b_q);
        end else begin
            // Both negative: larger magnitude is the smaller value
            lt_c = (mag_a_q > mag_b_q);
            gt_c = (mag_a_q < mag_b_q);
        end
    end

`ifdef FPU_CMP_INVALID_EN
    assign inv_c = snan_a_q | snan_b_q;
`else
    assign inv_c = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        a_ack_d  = a_ack_q;
        b_ack_d  = b_ack_q;
        z_stb_d  = z_stb_q;
        z_d      = z_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        nan_a_d  = nan_a_q;
        nan_b_d  = nan_b_q;
        zero_a_d = zero_a_q;
        zero_b_d = zero_b_q;
`ifdef FPU_CMP_INVALID_EN
        snan_a_d = snan_a_q;
        snan_b_d = snan_b_q;
`endif
        res_d    = res_q;

        case (state_q)
            GET_A: begin
                a_ack_d = 1'b1;
                if (i_a_stb && a_ack_q) begin
                    a_d     = i_a;
                    a_ack_d = 1'b0;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                b_ack_d = 1'b1;
                if (i_b_stb && b_ack_q) begin
                    b_d     = i_b;
                    b_ack_d = 1'b0;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_a_d = a_q[W_DATA-1];
                sign_b_d = b_q[W_DATA-1];
                mag_a_d  = a_q[W_MAG-1:0];
                mag_b_d  = b_q[W_MAG-1:0];
                nan_a_d  = (&exp_a_c) && (|frac_a_c);
                nan_b_d  = (&exp_b_c) && (|frac_b_c);
                zero_a_d = (~|exp_a_c) && (~|frac_a_c);
                zero_b_d = (~|exp_b_c) && (~|frac_b_c);
`ifdef FPU_CMP_INVALID_EN
                snan_a_d = (&exp_a_c) && (|frac_a_c) && !frac_a_c[W_FRAC-1];
                snan_b_d = (&exp_b_c) && (|frac_b_c) && !frac_b_c[W_FRAC-1];
`endif
                state_d  = COMPARE;
            end
            COMPARE: begin
                res_d   = {inv_c, unord_c, gt_c, eq_c, lt_c};
                state_d = PUT_Z;
            end
            PUT_Z: begin
                if (!z_stb_q) begin
                    z_stb_d = 1'b1;
                    z_d     = {{(W_DATA-W_RES){1'b0}}, res_q};
                end else if (i_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = GET_A;
                end
            end
            default: begin
                state_d = GET_A;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= GET_A;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            z_stb_q  <= 1'b0;
            z_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            nan_a_q  <= 1'b0;
            nan_b_q  <= 1'b0;
            zero_a_q <= 1'b0;
            zero_b_q <= 1'b0;
`ifdef FPU_CMP_INVALID_EN
            snan_a_q <= 1'b0;
            snan_b_q <= 1'b0;
`endif
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_ack_q  <= a_ack_d;
            b_ack_q  <= b_ack_d;
            z_stb_q  <= z_stb_d;
            z_q      <= z_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            nan_a_q  <= nan_a_d;
            nan_b_q  <= nan_b_d;
            zero_a_q <= zero_a_d;
            zero_b_q <= zero_b_d;
`ifdef FPU_CMP_INVALID_EN
            snan_a_q <= snan_a_d;
            snan_b_q <= snan_b_d;
`endif
            res_q    <= res_d;
        end
    end

    assign o_a_ack = a_ack_q;
    assign o_b_ack = b_ack_q;
    assign o_z_stb = z_stb_q;
    assign o_z     = z_q;

endmodule
